// File: rtl/hello_pkg.sv
// Shared HELLO-format constants, header field positions and deframer state encoding.
package hello_pkg;

    localparam logic [3:0] FTYPE_SWRITE = 4'h6;
    localparam logic [3:0] TTYPE_SWRITE = 4'h0;

    localparam int TID_HI   = 63;
    localparam int TID_LO   = 56;
    localparam int FTYPE_HI = 55;
    localparam int FTYPE_LO = 52;
    localparam int TTYPE_HI = 51;
    localparam int TTYPE_LO = 48;
    localparam int SIZE_HI  = 43;
    localparam int SIZE_LO  = 36;
    localparam int ADDR_HI  = 33;
    localparam int ADDR_LO  = 0;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        META    = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } hello_state_t;

    function automatic logic is_swrite(input logic [63:0] hdr);
        return (hdr[FTYPE_HI:FTYPE_LO] == FTYPE_SWRITE) &&
               (hdr[TTYPE_HI:TTYPE_LO] == TTYPE_SWRITE);
    endfunction

    // SIZE is bytes minus one, payload beats are 8 bytes: 1..32 beats.
    function automatic logic [5:0] exp_beats(input logic [7:0] size);
        return {1'b0, size[7:3]} + 6'd1;
    endfunction

endpackage

// File: rtl/hello_axis_skid.sv
// Two-entry AXIS skid buffer (data + last) with fully registered outputs.
module hello_axis_skid #(
    parameter int W = 64
) (
    input  logic         AXIS_ACLK,
    input  logic         AXIS_ARESET,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         skid_last;
    logic         s_fire;

    // Ready depends only on a register, so it never combinationally follows m_ready.
    assign s_ready = !skid_valid;
    assign s_fire  = s_valid && s_ready;

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (m_valid && !m_ready) begin
            if (s_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= s_data;
                skid_last  <= s_last;
            end
        end else if (skid_valid) begin
            m_valid    <= 1'b1;
            m_data     <= skid_data;
            m_last     <= skid_last;
            skid_valid <= 1'b0;
        end else begin
            m_valid <= s_fire;
            if (s_fire) begin
                m_data <= s_data;
                m_last <= s_last;
            end
        end
    end

endmodule

// File: rtl/hello_swrite_deframer.sv
// Parses HELLO SWRITE headers into one metadata transfer, then forwards the
// payload-only stream with length checking; non-SWRITE packets are dropped.
module hello_swrite_deframer
    import hello_pkg::*;
#(
    parameter int ADDR_W = 34,
    parameter int CNT_W  = 16
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [63:0]       S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    input  logic [31:0]       S_AXIS_TUSER,
    output logic              META_VALID,
    input  logic              META_READY,
    output logic [ADDR_W-1:0] META_ADDR,
    output logic [7:0]        META_SIZE,
    output logic [7:0]        META_TID,
    output logic [31:0]       META_TUSER,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [63:0]       M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              err_len,
    output logic              err_ftype,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count
);

    hello_state_t state;
    logic [5:0]   beat_cnt;
    logic [5:0]   beat_exp;
    logic         skid_s_ready;
    logic         s_fire;
    logic         hdr_sw;
    logic         last_exp;
    logic         ftype_evt;
    logic         len_evt;
    logic         pay_good;

    // Valid/ready: a beat transfers on any rising edge where TVALID and TREADY are both high.
    always_comb begin
        S_AXIS_TREADY = 1'b0;
        case (state)
            HDR, DROP: S_AXIS_TREADY = 1'b1;
            META:      S_AXIS_TREADY = 1'b0;
            PAYLOAD:   S_AXIS_TREADY = skid_s_ready;
            default:   S_AXIS_TREADY = 1'b0;
        endcase
        if (AXIS_ARESET) S_AXIS_TREADY = 1'b0;
    end

    assign s_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
    assign hdr_sw    = is_swrite(S_AXIS_TDATA);
    assign last_exp  = (beat_cnt + 6'd1) == beat_exp;
    assign ftype_evt = s_fire && (state == HDR) && !hdr_sw;
    assign pay_good  = s_fire && (state == PAYLOAD) && S_AXIS_TLAST && last_exp;
    // Header-only SWRITE, short packet, or long packet.
    assign len_evt   = (s_fire && (state == HDR) && hdr_sw && S_AXIS_TLAST) ||
                       (s_fire && (state == PAYLOAD) && (S_AXIS_TLAST != last_exp));

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state      <= HDR;
            beat_cnt   <= '0;
            beat_exp   <= '0;
            META_VALID <= 1'b0;
            META_ADDR  <= '0;
            META_SIZE  <= '0;
            META_TID   <= '0;
            META_TUSER <= '0;
            err_len    <= 1'b0;
            err_ftype  <= 1'b0;
            pkt_count  <= '0;
            err_count  <= '0;
        end else begin
            err_len   <= len_evt;
            err_ftype <= ftype_evt;
            if ((len_evt || ftype_evt) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            if (pay_good && (pkt_count != '1)) pkt_count <= pkt_count + CNT_W'(1);

            case (state)
                HDR: begin
                    if (s_fire) begin
                        if (!hdr_sw) begin
                            state <= S_AXIS_TLAST ? HDR : DROP;
                        end else if (!S_AXIS_TLAST) begin
                            META_VALID <= 1'b1;
                            META_ADDR  <= S_AXIS_TDATA[ADDR_W-1:0];
                            META_SIZE  <= S_AXIS_TDATA[SIZE_HI:SIZE_LO];
                            META_TID   <= S_AXIS_TDATA[TID_HI:TID_LO];
                            META_TUSER <= S_AXIS_TUSER;
                            beat_exp   <= exp_beats(S_AXIS_TDATA[SIZE_HI:SIZE_LO]);
                            beat_cnt   <= '0;
                            state      <= META;
                        end
                    end
                end
                META: begin
                    if (META_READY) begin
                        META_VALID <= 1'b0;
                        state      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (s_fire) begin
                        beat_cnt <= beat_cnt + 6'd1;
                        if (S_AXIS_TLAST)  state <= HDR;
                        else if (last_exp) state <= DROP;
                    end
                end
                DROP: begin
                    if (s_fire && S_AXIS_TLAST) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

    // A long packet gets TLAST forced on the beat that reaches the expected count.
    hello_axis_skid #(.W(64)) u_skid (
        .AXIS_ACLK   (AXIS_ACLK),
        .AXIS_ARESET (AXIS_ARESET),
        .s_valid     (S_AXIS_TVALID && (state == PAYLOAD)),
        .s_ready     (skid_s_ready),
        .s_data      (S_AXIS_TDATA),
        .s_last      (S_AXIS_TLAST || last_exp),
        .m_valid     (M_AXIS_TVALID),
        .m_ready     (M_AXIS_TREADY),
        .m_data      (M_AXIS_TDATA),
        .m_last      (M_AXIS_TLAST)
    );

endmodule

// File: tb/tb_hello_swrite_deframer.sv
// Directed bench for hello_swrite_deframer: header decode, drop, length errors,
// backpressure and mid-packet reset.
module tb_hello_swrite_deframer;

    localparam int W = 65;

    logic        AXIS_ACLK = 1'b0;
    logic        AXIS_ARESET = 1'b1;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic [63:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TLAST = 1'b0;
    logic [31:0] S_AXIS_TUSER = '0;
    logic        META_VALID;
    logic        META_READY = 1'b1;
    logic [33:0] META_ADDR;
    logic [7:0]  META_SIZE;
    logic [7:0]  META_TID;
    logic [31:0] META_TUSER;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;
    logic [63:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        err_len;
    logic        err_ftype;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    hello_swrite_deframer #(.ADDR_W(34), .CNT_W(16)) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESET   (AXIS_ARESET),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .META_VALID    (META_VALID),
        .META_READY    (META_READY),
        .META_ADDR     (META_ADDR),
        .META_SIZE     (META_SIZE),
        .META_TID      (META_TID),
        .META_TUSER    (META_TUSER),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .err_len       (err_len),
        .err_ftype     (err_ftype),
        .pkt_count     (pkt_count),
        .err_count     (err_count)
    );

    // Clock / reset
    always #5 AXIS_ACLK = ~AXIS_ACLK;

    int n_pass = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    // Monitor-owned observations; tests read them as deltas.
    int           meta_seen = 0;
    int           n_err_len = 0;
    int           n_err_ftype = 0;
    int           stall_obs = 0;
    int           stall_viol = 0;
    int           meta_viol = 0;
    logic [33:0]  got_addr = '0;
    logic [7:0]   got_size = '0;
    logic [7:0]   got_tid = '0;
    logic [31:0]  got_tuser = '0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_beat = '0;
    logic         meta_hold = 1'b0;
    logic [81:0]  meta_prev = '0;
    logic         tx_done = 1'b0;

    always @(negedge AXIS_ACLK) begin
        if (!AXIS_ARESET) begin
            if (M_AXIS_TVALID && M_AXIS_TREADY) got_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
            if (stall_prev) begin
                stall_obs++;
                if (!M_AXIS_TVALID || {M_AXIS_TLAST, M_AXIS_TDATA} !== stall_beat) stall_viol++;
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            stall_beat = {M_AXIS_TLAST, M_AXIS_TDATA};
            if (meta_hold && {META_VALID, META_ADDR, META_SIZE, META_TID, META_TUSER} !== {1'b1, meta_prev})
                meta_viol++;
            if (META_VALID && S_AXIS_TREADY !== 1'b0) meta_viol++;
            meta_hold = META_VALID && !META_READY;
            meta_prev = {META_ADDR, META_SIZE, META_TID, META_TUSER};
            if (META_VALID && META_READY) begin
                meta_seen++;
                got_addr  = META_ADDR;
                got_size  = META_SIZE;
                got_tid   = META_TID;
                got_tuser = META_TUSER;
            end
            if (err_len) n_err_len++;
            if (err_ftype) n_err_ftype++;
        end else begin
            stall_prev = 1'b0;
            meta_hold  = 1'b0;
        end
    end

    function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [3:0] ft,
                                           input logic [3:0] tt, input logic [7:0] sz,
                                           input logic [33:0] ad);
        return {tid, ft, tt, 4'h0, sz, 2'b00, ad};
    endfunction

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [31:0] u);
        int guard;
        guard = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TUSER  = u;
        @(negedge AXIS_ACLK);
        while (!S_AXIS_TREADY && guard < 200) begin
            @(negedge AXIS_ACLK);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL send_timeout: beat %h not accepted within 200 cycles", d);
        end
        @(posedge AXIS_ACLK);
        #1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge AXIS_ACLK);
        #1;
        n_total++;
        if ({S_AXIS_TREADY, META_VALID, M_AXIS_TVALID, err_len, err_ftype} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {S_AXIS_TREADY, META_VALID, M_AXIS_TVALID, err_len, err_ftype});
        else n_pass++;
        n_total++;
        if ({pkt_count, err_count, META_ADDR, M_AXIS_TDATA} !== '0)
            $display("FAIL reset_values: pkt=%0d err=%0d addr=%h mdata=%h expected all 0",
                     pkt_count, err_count, META_ADDR, M_AXIS_TDATA);
        else n_pass++;
        AXIS_ARESET = 1'b0;
        idle(1);
        n_total++;
        if (S_AXIS_TREADY !== 1'b1) $display("FAIL reset_hdr_ready: got %b expected 1", S_AXIS_TREADY);
        else n_pass++;
    endtask

    task automatic test_swrite_basic();
        int gb, mb, eb, fb;
        gb = got_q.size(); mb = meta_seen; eb = n_err_len; fb = n_err_ftype;
        exp_q.delete();
        exp_q.push_back({1'b0, 64'h1111_2222_3333_4444});
        exp_q.push_back({1'b1, 64'h5555_6666_7777_8888});
        send_beat(mk_hdr(8'h5A, 4'h6, 4'h0, 8'h0F, 34'h1_0000_0040), 1'b0, 32'hABCD_0102);
        send_beat(64'h1111_2222_3333_4444, 1'b0, 32'h0);
        send_beat(64'h5555_6666_7777_8888, 1'b1, 32'h0);
        idle(5);
        n_total++;
        if (meta_seen - mb !== 1) $display("FAIL basic_meta_count: got %0d expected 1", meta_seen - mb);
        else n_pass++;
        n_total++;
        if ({got_addr, got_size, got_tid, got_tuser} !== {34'h1_0000_0040, 8'h0F, 8'h5A, 32'hABCD_0102})
            $display("FAIL basic_meta: addr=%h size=%h tid=%h tuser=%h expected 100000040 0f 5a abcd0102",
                     got_addr, got_size, got_tid, got_tuser);
        else n_pass++;
        n_total++;
        if (got_q.size() - gb !== exp_q.size())
            $display("FAIL basic_beats: got %0d expected %0d", got_q.size() - gb, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (got_q.size() <= gb + i || got_q[gb+i] !== exp_q[i])
                $display("FAIL basic_beat%0d: got %h expected %h", i, (got_q.size() > gb + i) ? got_q[gb+i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (pkt_count !== 16'd1) $display("FAIL basic_pkt_count: got %0d expected 1", pkt_count);
        else n_pass++;
        n_total++;
        if ((n_err_len - eb) + (n_err_ftype - fb) !== 0 || err_count !== 16'd0)
            $display("FAIL basic_no_err: pulses=%0d err_count=%0d expected 0 0",
                     (n_err_len - eb) + (n_err_ftype - fb), err_count);
        else n_pass++;
    endtask

    task automatic test_ftype_drop();
        int gb, mb, fb;
        gb = got_q.size(); mb = meta_seen; fb = n_err_ftype;
        send_beat(mk_hdr(8'h11, 4'h5, 4'h0, 8'h0F, 34'h0_0000_1000), 1'b0, 32'h1);
        send_beat(64'hDEAD_0000_0000_0001, 1'b0, 32'h0);
        send_beat(64'hDEAD_0000_0000_0002, 1'b1, 32'h0);
        idle(4);
        n_total++;
        if (meta_seen - mb !== 0 || got_q.size() - gb !== 0)
            $display("FAIL ftype_forwarded: meta=%0d beats=%0d expected 0 0", meta_seen - mb, got_q.size() - gb);
        else n_pass++;
        n_total++;
        if (n_err_ftype - fb !== 1) $display("FAIL ftype_pulse: got %0d expected 1", n_err_ftype - fb);
        else n_pass++;
        n_total++;
        if (err_count !== 16'd1) $display("FAIL ftype_err_count: got %0d expected 1", err_count);
        else n_pass++;
    endtask

    task automatic test_short_packet();
        int gb, eb, mb;
        gb = got_q.size(); eb = n_err_len;
        exp_q.delete();
        exp_q.push_back({1'b0, 64'hA0A0_0000_0000_0001});
        exp_q.push_back({1'b1, 64'hA0A0_0000_0000_0002});
        send_beat(mk_hdr(8'h22, 4'h6, 4'h0, 8'h17, 34'h0_0000_2000), 1'b0, 32'h2);
        send_beat(64'hA0A0_0000_0000_0001, 1'b0, 32'h0);
        send_beat(64'hA0A0_0000_0000_0002, 1'b1, 32'h0);
        idle(4);
        n_total++;
        if (got_q.size() - gb !== 2) $display("FAIL short_beats: got %0d expected 2", got_q.size() - gb);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (got_q.size() <= gb + i || got_q[gb+i] !== exp_q[i])
                $display("FAIL short_beat%0d: got %h expected %h", i, (got_q.size() > gb + i) ? got_q[gb+i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (n_err_len - eb !== 1 || err_count !== 16'd2)
            $display("FAIL short_err: pulses=%0d err_count=%0d expected 1 2", n_err_len - eb, err_count);
        else n_pass++;
        // Following packet must decode as a fresh header.
        gb = got_q.size(); mb = meta_seen;
        send_beat(mk_hdr(8'h33, 4'h6, 4'h0, 8'h07, 34'h2_0000_0008), 1'b0, 32'h3);
        send_beat(64'hB0B0_0000_0000_0001, 1'b1, 32'h0);
        idle(4);
        n_total++;
        if (meta_seen - mb !== 1 || got_tid !== 8'h33 || got_addr !== 34'h2_0000_0008)
            $display("FAIL short_next_meta: n=%0d tid=%h addr=%h expected 1 33 200000008", meta_seen - mb, got_tid, got_addr);
        else n_pass++;
        n_total++;
        if (got_q.size() - gb !== 1 || got_q[got_q.size()-1] !== {1'b1, 64'hB0B0_0000_0000_0001})
            $display("FAIL short_next_beat: n=%0d expected 1 beat 1b0b0000000000001", got_q.size() - gb);
        else n_pass++;
        n_total++;
        if (pkt_count !== 16'd2) $display("FAIL short_pkt_count: got %0d expected 2", pkt_count);
        else n_pass++;
    endtask

    task automatic test_long_packet();
        int gb, eb;
        gb = got_q.size(); eb = n_err_len;
        send_beat(mk_hdr(8'h44, 4'h6, 4'h0, 8'h07, 34'h0_0000_3000), 1'b0, 32'h4);
        send_beat(64'hC0C0_0000_0000_0001, 1'b0, 32'h0);
        send_beat(64'hC0C0_0000_0000_0002, 1'b0, 32'h0);
        send_beat(64'hC0C0_0000_0000_0003, 1'b1, 32'h0);
        idle(4);
        n_total++;
        if (got_q.size() - gb !== 1) $display("FAIL long_beats: got %0d expected 1", got_q.size() - gb);
        else n_pass++;
        n_total++;
        if (got_q.size() <= gb || got_q[gb] !== {1'b1, 64'hC0C0_0000_0000_0001})
            $display("FAIL long_forced_last: got %h expected 1c0c0000000000001", (got_q.size() > gb) ? got_q[gb] : '0);
        else n_pass++;
        n_total++;
        if (n_err_len - eb !== 1 || err_count !== 16'd3 || pkt_count !== 16'd2)
            $display("FAIL long_err: pulses=%0d err_count=%0d pkt=%0d expected 1 3 2",
                     n_err_len - eb, err_count, pkt_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int gb, mb, eb, sb, vb, guard;
        gb = got_q.size(); mb = meta_seen; eb = n_err_len; sb = stall_obs; vb = stall_viol;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), 64'hD000_0000_0000_0000 + 64'(i)});
        META_READY = 1'b0;
        tx_done = 1'b0;
        fork
            begin
                send_beat(mk_hdr(8'h77, 4'h6, 4'h0, 8'hFF, 34'h3_FFFF_FFF8), 1'b0, 32'h7);
                for (int i = 0; i < 32; i++) send_beat(64'hD000_0000_0000_0000 + 64'(i), (i == 31), 32'h0);
                tx_done = 1'b1;
            end
            begin
                guard = 0;
                @(negedge AXIS_ACLK);
                while (!META_VALID && guard < 100) begin
                    @(negedge AXIS_ACLK);
                    guard++;
                end
                repeat (5) @(posedge AXIS_ACLK);
                #1;
                META_READY = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(posedge AXIS_ACLK);
                    #1;
                    M_AXIS_TREADY = ~M_AXIS_TREADY;
                end
            end
        join
        M_AXIS_TREADY = 1'b1;
        idle(8);
        n_total++;
        if (meta_seen - mb !== 1 || got_size !== 8'hFF || got_tid !== 8'h77)
            $display("FAIL bp_meta: n=%0d size=%h tid=%h expected 1 ff 77", meta_seen - mb, got_size, got_tid);
        else n_pass++;
        n_total++;
        if (meta_viol !== 0) $display("FAIL bp_meta_hold: violations=%0d expected 0", meta_viol);
        else n_pass++;
        n_total++;
        if (got_q.size() - gb !== 32) $display("FAIL bp_beats: got %0d expected 32", got_q.size() - gb);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (got_q.size() <= gb + i || got_q[gb+i] !== exp_q[i])
                $display("FAIL bp_beat%0d: got %h expected %h", i, (got_q.size() > gb + i) ? got_q[gb+i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (stall_obs - sb < 1 || stall_viol - vb !== 0)
            $display("FAIL bp_stall_stable: stalls=%0d violations=%0d expected >0 0", stall_obs - sb, stall_viol - vb);
        else n_pass++;
        n_total++;
        if (pkt_count !== 16'd3 || n_err_len - eb !== 0)
            $display("FAIL bp_counts: pkt=%0d err_len=%0d expected 3 0", pkt_count, n_err_len - eb);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int gb, mb, eb, fb;
        send_beat(mk_hdr(8'h01, 4'h6, 4'h0, 8'hFF, 34'h0_0000_0000), 1'b0, 32'h9);
        for (int i = 0; i < 9; i++) send_beat(64'hE000_0000_0000_0000 + 64'(i), 1'b0, 32'h0);
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 64'hE000_0000_0000_0009;
        #2;
        AXIS_ARESET = 1'b1;
        #1;
        n_total++;
        if ({S_AXIS_TREADY, META_VALID, M_AXIS_TVALID, M_AXIS_TLAST, err_len, err_ftype} !== 6'b0)
            $display("FAIL rst_mid_flags: got %b expected 000000",
                     {S_AXIS_TREADY, META_VALID, M_AXIS_TVALID, M_AXIS_TLAST, err_len, err_ftype});
        else n_pass++;
        n_total++;
        if ({pkt_count, err_count, M_AXIS_TDATA, META_ADDR, META_TID} !== '0)
            $display("FAIL rst_mid_values: pkt=%0d err=%0d mdata=%h addr=%h expected all 0",
                     pkt_count, err_count, M_AXIS_TDATA, META_ADDR);
        else n_pass++;
        S_AXIS_TVALID = 1'b0;
        repeat (2) @(posedge AXIS_ACLK);
        #3;
        AXIS_ARESET = 1'b0;
        idle(1);
        gb = got_q.size(); mb = meta_seen; eb = n_err_len; fb = n_err_ftype;
        send_beat(mk_hdr(8'h02, 4'h6, 4'h0, 8'h07, 34'h0_0000_0100), 1'b1, 32'h0);
        idle(4);
        n_total++;
        if (n_err_len - eb !== 1 || n_err_ftype - fb !== 0 || err_count !== 16'd1)
            $display("FAIL rst_hdr_only: err_len=%0d err_ftype=%0d err_count=%0d expected 1 0 1",
                     n_err_len - eb, n_err_ftype - fb, err_count);
        else n_pass++;
        n_total++;
        if (meta_seen - mb !== 0 || got_q.size() - gb !== 0 || pkt_count !== 16'd0)
            $display("FAIL rst_hdr_only_quiet: meta=%0d beats=%0d pkt=%0d expected 0 0 0",
                     meta_seen - mb, got_q.size() - gb, pkt_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_swrite_basic();
        test_ftype_drop();
        test_short_packet();
        test_long_packet();
        test_backpressure();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
